// File: rtl/polar_sched_pkg.sv
// polar_sched_pkg: shared types and widths for the polar encoder round-robin scheduler
package polar_sched_pkg;
  localparam int K_DATA_W  = 24;
  localparam int CW_W      = 64;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr modulo N
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_gnt
);
  // scan from the farthest slot back to ptr so the closest requester wins
  always_comb begin
    idx = '0;
    any_gnt = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any_gnt = 1'b1;
      end
    end
    gnt = any_gnt ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/polar_enc_rr_scheduler.sv
// polar_enc_rr_scheduler: shares one polar encoder among N_REQ requesters; optional WAIT watchdog via POLAR_SCHED_TIMEOUT_EN
module polar_enc_rr_scheduler
  import polar_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [K_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_id,
  output logic [CW_W-1:0]           out_codeword,
  output logic                      enc_start,
  output logic [K_DATA_W-1:0]       enc_data,
  input  logic                      enc_done,
  input  logic [CW_W-1:0]           enc_codeword,
  output logic                      busy,
  output logic                      err_stray,
  output logic                      err_timeout
);
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, gnt_idx, lat_id;
  logic [N_REQ-1:0] gnt;
  logic any_gnt, acc, to_hit;
  logic [K_DATA_W-1:0] gnt_data;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req(req_valid), .ptr(ptr), .gnt(gnt), .idx(gnt_idx), .any_gnt(any_gnt)
  );

  assign gnt_data = req_data[K_DATA_W*gnt_idx +: K_DATA_W];
  assign acc = (state == IDLE) && any_gnt;

`ifdef POLAR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  assign to_hit = cnt == CNT_W'(TIMEOUT - 1);
  // WAIT-cycle counter (zero outside WAIT) and one-cycle expiry pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      err_timeout <= (state == WAIT) && !enc_done && to_hit;
    end
`else
  assign to_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // next-state logic; a watchdog expiry drops the job back to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = any_gnt ? ISSUE : IDLE;
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = enc_done ? HOLD : (to_hit ? IDLE : WAIT);
      HOLD:  state_nx = out_ready ? IDLE : HOLD;
    endcase
  end

  // state-decoded outputs; req_ready is held low while reset is asserted
  always_comb begin
    req_ready = (state == IDLE && rst_n) ? gnt : '0;
    enc_start = state == ISSUE;
    out_valid = state == HOLD;
    busy      = state != IDLE;
  end

  // latch the winner's payload and ID and advance the pointer past it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      lat_id <= '0;
      enc_data <= '0;
    end else if (acc) begin
      ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      lat_id <= gnt_idx;
      enc_data <= gnt_data;
    end

  // capture the encoder result only when a job is waiting on it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_id <= '0;
      out_codeword <= '0;
    end else if (state == WAIT && enc_done) begin
      out_id <= lat_id;
      out_codeword <= enc_codeword;
    end

  // sticky flag for done pulses nobody is waiting for
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_stray <= 1'b0;
    else if (enc_done && state != WAIT) err_stray <= 1'b1;
endmodule

// File: tb/tb_polar_enc_rr_scheduler.sv
// tb_polar_enc_rr_scheduler: directed table-driven bench with a behavioural encoder stand-in
module tb_polar_enc_rr_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [95:0] req_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [1:0] out_id;
  logic [63:0] out_codeword, enc_codeword;
  logic enc_start, enc_done, busy, err_stray, err_timeout;
  logic [23:0] enc_data;
  logic [2:0] sr = '0;
  logic [63:0] cw_q = '0;
  logic inj = 1'b0, kill = 1'b0;
  int passed = 0, total = 0;

  polar_enc_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_codeword(out_codeword), .enc_start(enc_start),
    .enc_data(enc_data), .enc_done(enc_done), .enc_codeword(enc_codeword),
    .busy(busy), .err_stray(err_stray), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cw_of(input logic [23:0] d);
    return {d, ~d[15:0], d[23:8] ^ 16'hA5C3, d[7:0]};
  endfunction

  always @(posedge clk) begin
    sr <= {sr[1:0], enc_start & ~kill};
    if (enc_start) cw_q <= cw_of(enc_data);
  end
  assign enc_done = sr[2] | inj;
  assign enc_codeword = cw_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic job(input logic [3:0] rv, input logic [95:0] d, input int id);
    logic [23:0] pay;
    pay = d[24*id +: 24];
    req_valid = rv; req_data = d; out_ready = 1'b1; #1;
    chk("grant", 64'(req_ready), 64'(4'b0001 << id));
    chk("busy_idle", 64'(busy), 0);
    @(negedge clk); #1;
    chk("enc_start", 64'(enc_start), 1);
    chk("enc_data", 64'(enc_data), 64'(pay));
    chk("ready_issue", 64'(req_ready), 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("no_out_early", 64'(out_valid), 0);
      chk("start_once", 64'(enc_start), 0);
    end
    @(negedge clk); #1;
    chk("out_valid", 64'(out_valid), 1);
    chk("out_id", 64'(out_id), 64'(id));
    chk("out_codeword", out_codeword, cw_of(pay));
    chk("no_timeout", 64'(err_timeout), 0);
    @(negedge clk); req_valid = '0; #1;
    chk("busy_done", 64'(busy), 0);
    chk("out_valid_fall", 64'(out_valid), 0);
  endtask

  typedef struct { logic rst; logic [3:0] rv; logic [95:0] d; int id; } vec_t;
  vec_t tbl[11];
  localparam logic [95:0] D = {24'h000004, 24'h000003, 24'h000002, 24'h000001};

  initial begin
    tbl[0]  = '{1'b0, 4'b0100, {24'h111111, 24'hABCDEF, 24'h222222, 24'h333333}, 2};
    tbl[1]  = '{1'b0, 4'b0001, {24'h444444, 24'h555555, 24'h666666, 24'h123456}, 0};
    tbl[2]  = '{1'b0, 4'b1000, {24'hFFFFFF, 24'h0F0F0F, 24'hF0F0F0, 24'h777777}, 3};
    tbl[3]  = '{1'b0, 4'b0010, {24'h888888, 24'h999999, 24'h000000, 24'hAAAAAA}, 1};
    tbl[4]  = '{1'b0, 4'b1011, {24'hC0FFEE, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD}, 3};
    tbl[5]  = '{1'b0, 4'b0110, {24'hEEEEEE, 24'h13579B, 24'h2468AC, 24'h010101}, 1};
    tbl[6]  = '{1'b1, 4'b1111, D, 0};
    tbl[7]  = '{1'b0, 4'b1111, D, 1};
    tbl[8]  = '{1'b0, 4'b1111, D, 2};
    tbl[9]  = '{1'b0, 4'b1111, D, 3};
    tbl[10] = '{1'b0, 4'b1111, D, 0};

    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_id", 64'(out_id), 0);
    chk("rst_codeword", out_codeword, 0);
    chk("rst_enc_start", 64'(enc_start), 0);
    chk("rst_enc_data", 64'(enc_data), 0);
    chk("rst_err_stray", 64'(err_stray), 0);
    chk("rst_err_timeout", 64'(err_timeout), 0);
    @(negedge clk);
    req_valid = '0; rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      job(tbl[i].rv, tbl[i].d, tbl[i].id);
    end

    req_valid = 4'b0001; req_data = D; out_ready = 1'b0; #1;
    chk("stall_grant", 64'(req_ready), 64'(4'b0001));
    repeat (5) @(negedge clk);
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_id", 64'(out_id), 0);
      chk("stall_cw", out_codeword, cw_of(24'h000001));
      chk("stall_ready", 64'(req_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    chk("stall_release_valid", 64'(out_valid), 1);
    @(negedge clk); req_valid = '0; #1;
    chk("stall_after_valid", 64'(out_valid), 0);
    chk("stall_after_busy", 64'(busy), 0);

    inj = 1'b1; #1;
    chk("stray_pre", 64'(err_stray), 0);
    @(negedge clk); inj = 1'b0; #1;
    chk("stray_set", 64'(err_stray), 1);
    chk("stray_no_out", 64'(out_valid), 0);
    chk("stray_idle", 64'(busy), 0);
    job(4'b0100, {24'h5A5A5A, 24'h3C3C3C, 24'h969696, 24'h0000FF}, 2);
    chk("stray_sticky", 64'(err_stray), 1);

    req_valid = 4'b1000; req_data = D; #1;
    chk("rstw_grant", 64'(req_ready), 64'(4'b1000));
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    req_valid = 4'b1010; rst_n = 1'b0; #1;
    chk("rstw_busy", 64'(busy), 0);
    chk("rstw_ready", 64'(req_ready), 0);
    chk("rstw_enc_data", 64'(enc_data), 0);
    chk("rstw_out_id", 64'(out_id), 0);
    chk("rstw_cw", out_codeword, 0);
    chk("rstw_stray", 64'(err_stray), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    job(4'b1010, D, 1);
    chk("rstw_stray_after", 64'(err_stray), 0);

`ifdef POLAR_SCHED_TIMEOUT_EN
    kill = 1'b1;
    req_valid = 4'b0100; #1;
    chk("to_grant", 64'(req_ready), 64'(4'b0100));
    @(negedge clk); req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      chk("to_quiet", 64'(err_timeout), 0);
      chk("to_busy", 64'(busy), 1);
    end
    @(negedge clk); req_valid = 4'hF; #1;
    chk("to_pulse", 64'(err_timeout), 1);
    chk("to_idle", 64'(busy), 0);
    chk("to_no_out", 64'(out_valid), 0);
    chk("to_next_grant", 64'(req_ready), 64'(4'b1000));
    #1 req_valid = '0;
    @(negedge clk); #1;
    chk("to_pulse_end", 64'(err_timeout), 0);
    kill = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
